// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the two bus requesters, the memory/IO decode and the arbiter.
// The slave modport is the arbiter's view; the master modport is the view of the requesters and bus.
interface mem_bus_arbiter_if #(
    parameter int AW = 9,
    parameter int DW = 16
);
    logic [1:0]    req0_cmd;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req0_ack;
    logic [DW-1:0] req0_rdata;

    logic [1:0]    req1_cmd;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          req1_ack;
    logic [DW-1:0] req1_rdata;

    logic [1:0]    bus_cmd;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata;

    logic [1:0]    grant;
    logic          busy;

    modport slave (
        input  req0_cmd, req0_addr, req0_wdata,
        input  req1_cmd, req1_addr, req1_wdata,
        input  bus_rdata,
        output req0_ack, req0_rdata,
        output req1_ack, req1_rdata,
        output bus_cmd, bus_addr, bus_wdata,
        output grant, busy
    );

    modport master (
        output req0_cmd, req0_addr, req0_wdata,
        output req1_cmd, req1_addr, req1_wdata,
        output bus_rdata,
        input  req0_ack, req0_rdata,
        input  req1_ack, req1_rdata,
        input  bus_cmd, bus_addr, bus_wdata,
        input  grant, busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter sharing the RAM / memory-mapped IO bus between the CPU (port 0) and a secondary master (port 1).
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; by default port 0 has priority with a MAX_HOLD starvation guard.
module mem_bus_arbiter #(
    parameter int AW       = 9,
    parameter int DW       = 16,
    parameter int RD_LAT   = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset,
    mem_bus_arbiter_if.slave mbus
);

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } state_t;

    state_t        state;
    state_t        next_state;

    logic [1:0]    lat_cmd;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          owner;
    logic [2:0]    wait_cnt;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    logic          valid0;
    logic          valid1;
    logic          any_valid;
    logic          pick1;

    // Command 11 is treated exactly like "no request".
    assign valid0    = (mbus.req0_cmd == CMD_READ) || (mbus.req0_cmd == CMD_WRITE);
    assign valid1    = (mbus.req1_cmd == CMD_READ) || (mbus.req1_cmd == CMD_WRITE);
    assign any_valid = valid0 || valid1;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner;

    assign pick1 = valid1 && (!valid0 || !last_owner);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner <= 1'b0;
        end else if (state == IDLE && any_valid) begin
            last_owner <= pick1;
        end
    end
`else
    localparam int HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0] hold_cnt;

    // Port 1 only overrides port 0 once port 0 has been granted MAX_HOLD times in a row while port 1 waited.
    assign pick1 = valid1 && (!valid0 || (hold_cnt == HW'(MAX_HOLD)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (state == IDLE && any_valid) begin
            if (valid0 && valid1 && !pick1) begin
                hold_cnt <= hold_cnt + HW'(1);
            end else begin
                hold_cnt <= '0;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_valid) next_state = ACCESS;
            ACCESS:  next_state = (lat_cmd == CMD_READ) ? WAIT : DONE;
            WAIT:    if (wait_cnt == 3'd1) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Requests are latched in IDLE so the arbiter ignores requester inputs for the rest of the transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_cmd   <= CMD_NONE;
            lat_addr  <= '0;
            lat_wdata <= '0;
            owner     <= 1'b0;
            wait_cnt  <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        owner     <= pick1;
                        lat_cmd   <= pick1 ? mbus.req1_cmd   : mbus.req0_cmd;
                        lat_addr  <= pick1 ? mbus.req1_addr  : mbus.req0_addr;
                        lat_wdata <= pick1 ? mbus.req1_wdata : mbus.req0_wdata;
                    end
                end
                ACCESS: begin
                    wait_cnt <= 3'(RD_LAT);
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 3'd1;
                    if (wait_cnt == 3'd1) begin
                        if (owner) begin
                            rdata1_q <= mbus.bus_rdata;
                        end else begin
                            rdata0_q <= mbus.bus_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The read command stays on the bus through WAIT so the RAM / switch tristates remain enabled.
    always_comb begin
        mbus.bus_cmd  = CMD_NONE;
        mbus.grant    = 2'b00;
        mbus.busy     = 1'b0;
        mbus.req0_ack = 1'b0;
        mbus.req1_ack = 1'b0;
        case (state)
            ACCESS, WAIT: begin
                mbus.bus_cmd = lat_cmd;
                mbus.grant   = owner ? 2'b10 : 2'b01;
                mbus.busy    = 1'b1;
            end
            DONE: begin
                mbus.grant    = owner ? 2'b10 : 2'b01;
                mbus.busy     = 1'b1;
                mbus.req0_ack = !owner;
                mbus.req1_ack = owner;
            end
            default: begin
            end
        endcase
    end

    assign mbus.bus_addr   = lat_addr;
    assign mbus.bus_wdata  = lat_wdata;
    assign mbus.req0_rdata = rdata0_q;
    assign mbus.req1_rdata = rdata1_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard testbench for mem_bus_arbiter: one instance with RD_LAT=1 and one with RD_LAT=3,
// each attached to a small bus memory model that only returns valid data RD_LAT cycles after ACCESS.
module tb_mem_bus_arbiter;

    localparam int AW       = 9;
    localparam int DW       = 16;
    localparam int MAX_HOLD = 4;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_BAD   = 2'b11;

    typedef struct {
        int            port;
        int            lat;
        logic [DW-1:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    int vectors     = 0;
    int miscompares = 0;

    exp_t          exp_q[$];
    logic [DW-1:0] exp_rdata0;
    logic [DW-1:0] exp_rdata1;

    logic          preload_en = 1'b0;
    logic [AW-1:0] preload_addr = '0;
    logic [DW-1:0] preload_data = '0;

    logic [DW-1:0] mem_a [0:511];
    logic [DW-1:0] mem_b [0:511];
    int            read_age_a = 0;
    int            read_age_b = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.AW(AW), .DW(DW)) bus_a ();
    mem_bus_arbiter_if #(.AW(AW), .DW(DW)) bus_b ();

    mem_bus_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .mbus  (bus_a.slave)
    );

    mem_bus_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3), .MAX_HOLD(MAX_HOLD)) dut_lat3 (
        .clk   (clk),
        .reset (reset),
        .mbus  (bus_b.slave)
    );

    // Bus model: writes commit on the edge closing a write cycle; read data is garbage until the read has aged RD_LAT cycles.
    always @(posedge clk) begin
        if (preload_en) begin
            mem_a[preload_addr] <= preload_data;
            mem_b[preload_addr] <= preload_data;
        end else begin
            if (bus_a.bus_cmd == CMD_WRITE) mem_a[bus_a.bus_addr] <= bus_a.bus_wdata;
            if (bus_b.bus_cmd == CMD_WRITE) mem_b[bus_b.bus_addr] <= bus_b.bus_wdata;
        end
        read_age_a <= (bus_a.bus_cmd == CMD_READ) ? read_age_a + 1 : 0;
        read_age_b <= (bus_b.bus_cmd == CMD_READ) ? read_age_b + 1 : 0;
    end

    always_comb bus_a.bus_rdata = (bus_a.bus_cmd == CMD_READ && read_age_a >= 1) ? mem_a[bus_a.bus_addr] : 16'hDEAD;
    always_comb bus_b.bus_rdata = (bus_b.bus_cmd == CMD_READ && read_age_b >= 3) ? mem_b[bus_b.bus_addr] : 16'hDEAD;

    task automatic clear_requests();
        bus_a.req0_cmd = CMD_NONE; bus_a.req0_addr = '0; bus_a.req0_wdata = '0;
        bus_a.req1_cmd = CMD_NONE; bus_a.req1_addr = '0; bus_a.req1_wdata = '0;
        bus_b.req0_cmd = CMD_NONE; bus_b.req0_addr = '0; bus_b.req0_wdata = '0;
        bus_b.req1_cmd = CMD_NONE; bus_b.req1_addr = '0; bus_b.req1_wdata = '0;
    endtask

    task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        @(negedge clk);
        preload_en = 1'b1; preload_addr = addr; preload_data = data;
        @(negedge clk);
        preload_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_requests();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_rdata0 = '0;
        exp_rdata1 = '0;
    endtask

    task automatic test_reset();
        clear_requests();
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({bus_a.busy, bus_a.grant, bus_a.bus_cmd} !== 5'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got busy/grant/cmd %b, expected 00000", {bus_a.busy, bus_a.grant, bus_a.bus_cmd});
        end
        vectors++;
        if ({bus_a.bus_addr, bus_a.bus_wdata} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_bus: got addr %h wdata %h, expected 0 0", bus_a.bus_addr, bus_a.bus_wdata);
        end
        vectors++;
        if ({bus_a.req1_ack, bus_a.req0_ack} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_ack: got %b, expected 00", {bus_a.req1_ack, bus_a.req0_ack});
        end
        vectors++;
        if ({bus_a.req1_rdata, bus_a.req0_rdata} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_rdata: got %h %h, expected 0 0", bus_a.req1_rdata, bus_a.req0_rdata);
        end
        reset = 1'b0;
        exp_rdata0 = '0;
        exp_rdata1 = '0;
    endtask

    task automatic test_write();
        exp_t e;
        int   lat = -1;
        int   wr_cycles = 0;
        int   bad_bus = 0;
        int   stray = 0;
        @(negedge clk);
        bus_a.req0_cmd = CMD_WRITE; bus_a.req0_addr = 9'h005; bus_a.req0_wdata = 16'hBEEF;
        exp_q.push_back('{port: 0, lat: 2, rdata: 16'h0000});
        for (int k = 1; k <= 8 && lat < 0; k++) begin
            @(negedge clk);
            if (bus_a.bus_cmd == CMD_WRITE) begin
                wr_cycles++;
                if (bus_a.bus_addr !== 9'h005 || bus_a.bus_wdata !== 16'hBEEF || bus_a.grant !== 2'b01) bad_bus++;
            end
            if (bus_a.req1_ack) stray++;
            if (bus_a.req0_ack) lat = k;
        end
        bus_a.req0_cmd = CMD_NONE;
        e = exp_q.pop_front();
        vectors++;
        if (lat != e.lat) begin
            miscompares++;
            $display("[TB] FAIL write_latency: got %0d, expected %0d", lat, e.lat);
        end
        vectors++;
        if (wr_cycles != 1 || bad_bus != 0) begin
            miscompares++;
            $display("[TB] FAIL write_bus: got %0d write cycles (%0d wrong), expected 1 (0 wrong)", wr_cycles, bad_bus);
        end
        vectors++;
        if (stray != 0) begin
            miscompares++;
            $display("[TB] FAIL write_req1_ack: got %0d pulses, expected 0", stray);
        end
        vectors++;
        if (mem_a[9'h005] !== 16'hBEEF) begin
            miscompares++;
            $display("[TB] FAIL write_commit: got %h, expected beef", mem_a[9'h005]);
        end
        @(negedge clk);
        vectors++;
        if ({bus_a.busy, bus_a.req0_ack} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL write_ack_pulse: got busy/ack %b, expected 00", {bus_a.busy, bus_a.req0_ack});
        end
    endtask

    task automatic test_read();
        exp_t e;
        int   lat = -1;
        int   rd_cycles = 0;
        int   stray = 0;
        preload(9'h140, 16'h00A5);
        @(negedge clk);
        bus_a.req1_cmd = CMD_READ; bus_a.req1_addr = 9'h140; bus_a.req1_wdata = 16'h7777;
        exp_q.push_back('{port: 1, lat: 3, rdata: 16'h00A5});
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            @(negedge clk);
            if (bus_a.bus_cmd == CMD_READ) rd_cycles++;
            if (bus_a.req0_ack) stray++;
            if (bus_a.req1_ack) lat = k;
        end
        e = exp_q.pop_front();
        vectors++;
        if (lat != e.lat) begin
            miscompares++;
            $display("[TB] FAIL read_latency: got %0d, expected %0d", lat, e.lat);
        end
        vectors++;
        if (bus_a.req1_rdata !== e.rdata) begin
            miscompares++;
            $display("[TB] FAIL read_rdata1: got %h, expected %h", bus_a.req1_rdata, e.rdata);
        end
        vectors++;
        if (rd_cycles != 2 || stray != 0) begin
            miscompares++;
            $display("[TB] FAIL read_bus: got %0d read cycles, %0d req0 acks, expected 2 and 0", rd_cycles, stray);
        end
        vectors++;
        if (bus_a.req0_rdata !== exp_rdata0) begin
            miscompares++;
            $display("[TB] FAIL read_rdata0_hold: got %h, expected %h", bus_a.req0_rdata, exp_rdata0);
        end
        bus_a.req1_cmd = CMD_NONE;
        exp_rdata1 = 16'h00A5;
    endtask

    task automatic test_back_to_back();
        int lat = -1;
        @(negedge clk);
        bus_a.req0_cmd = CMD_WRITE; bus_a.req0_addr = 9'h0AA; bus_a.req0_wdata = 16'h1234;
        for (int k = 1; k <= 8 && lat < 0; k++) begin
            @(negedge clk);
            if (bus_a.req0_ack) lat = k;
        end
        bus_a.req0_cmd = CMD_READ;
        exp_q.push_back('{port: 0, lat: 3, rdata: 16'h1234});
        @(negedge clk);
        vectors++;
        if ({bus_a.busy, bus_a.grant} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL b2b_gap: got busy/grant %b, expected 000", {bus_a.busy, bus_a.grant});
        end
        lat = -1;
        for (int k = 1; k <= 8 && lat < 0; k++) begin
            @(negedge clk);
            if (bus_a.req0_ack) lat = k;
        end
        bus_a.req0_cmd = CMD_NONE;
        begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            if (lat != e.lat || bus_a.req0_rdata !== e.rdata) begin
                miscompares++;
                $display("[TB] FAIL b2b_read: got lat %0d data %h, expected lat %0d data %h", lat, bus_a.req0_rdata, e.lat, e.rdata);
            end
            exp_rdata0 = e.rdata;
        end
        vectors++;
        if (bus_a.req1_rdata !== exp_rdata1) begin
            miscompares++;
            $display("[TB] FAIL b2b_rdata1_hold: got %h, expected %h", bus_a.req1_rdata, exp_rdata1);
        end
    endtask

    task automatic test_invalid_cmd();
        int bad = 0;
        @(negedge clk);
        bus_a.req0_cmd = CMD_BAD; bus_a.req0_addr = 9'h033; bus_a.req0_wdata = 16'h5555;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus_a.busy !== 1'b0 || bus_a.grant !== 2'b00 || bus_a.req0_ack !== 1'b0 || bus_a.req1_ack !== 1'b0) bad++;
        end
        bus_a.req0_cmd = CMD_NONE;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL invalid_cmd: got %0d active cycles, expected 0", bad);
        end
    endtask

    task automatic test_rd_lat3();
        exp_t e;
        int   lat = -1;
        int   rd_cycles = 0;
        preload(9'h033, 16'h5A5A);
        @(negedge clk);
        bus_b.req0_cmd = CMD_READ; bus_b.req0_addr = 9'h033;
        exp_q.push_back('{port: 0, lat: 5, rdata: 16'h5A5A});
        for (int k = 1; k <= 12 && lat < 0; k++) begin
            @(negedge clk);
            if (bus_b.bus_cmd == CMD_READ) rd_cycles++;
            if (bus_b.req0_ack) lat = k;
        end
        bus_b.req0_cmd = CMD_NONE;
        e = exp_q.pop_front();
        vectors++;
        if (lat != e.lat || rd_cycles != 4) begin
            miscompares++;
            $display("[TB] FAIL lat3_timing: got lat %0d, %0d read cycles, expected %0d and 4", lat, rd_cycles, e.lat);
        end
        vectors++;
        if (bus_b.req0_rdata !== e.rdata) begin
            miscompares++;
            $display("[TB] FAIL lat3_rdata: got %h, expected %h", bus_b.req0_rdata, e.rdata);
        end
    endtask

    task automatic test_arbitration();
        exp_t          e;
        int            acks = 0;
        int            owner;
        logic [DW-1:0] got;
`ifdef ARB_ROUND_ROBIN_EN
        int            last = 0;
`else
        int            hold = 0;
`endif
        preload(9'h011, 16'h1111);
        preload(9'h122, 16'h2222);
        for (int i = 0; i < 10; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            owner = (last == 0) ? 1 : 0;
            last  = owner;
`else
            if (hold == MAX_HOLD) begin
                owner = 1;
                hold  = 0;
            end else begin
                owner = 0;
                hold++;
            end
`endif
            exp_q.push_back('{port: owner, lat: 0, rdata: (owner == 1) ? 16'h2222 : 16'h1111});
        end
        @(negedge clk);
        bus_a.req0_cmd = CMD_READ; bus_a.req0_addr = 9'h011;
        bus_a.req1_cmd = CMD_READ; bus_a.req1_addr = 9'h122;
        for (int k = 0; k < 80 && acks < 10; k++) begin
            @(negedge clk);
            if (bus_a.req0_ack || bus_a.req1_ack) begin
                e = exp_q.pop_front();
                vectors++;
                if ({bus_a.req1_ack, bus_a.req0_ack, bus_a.grant} !== ((e.port == 1) ? 4'b1010 : 4'b0101)) begin
                    miscompares++;
                    $display("[TB] FAIL arb_owner[%0d]: got ack/grant %b, expected port %0d", acks, {bus_a.req1_ack, bus_a.req0_ack, bus_a.grant}, e.port);
                end
                got = bus_a.req1_ack ? bus_a.req1_rdata : bus_a.req0_rdata;
                vectors++;
                if (got !== e.rdata) begin
                    miscompares++;
                    $display("[TB] FAIL arb_rdata[%0d]: got %h, expected %h", acks, got, e.rdata);
                end
                acks++;
            end
        end
        bus_a.req0_cmd = CMD_NONE;
        bus_a.req1_cmd = CMD_NONE;
        vectors++;
        if (acks != 10) begin
            miscompares++;
            $display("[TB] FAIL arb_count: got %0d acks, expected 10", acks);
        end
        exp_q.delete();
        exp_rdata0 = 16'h1111;
        exp_rdata1 = 16'h2222;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        vectors++;
        if (bus_a.req0_rdata !== exp_rdata0) begin
            miscompares++;
            $display("[TB] FAIL mid_pre_rdata0: got %h, expected %h", bus_a.req0_rdata, exp_rdata0);
        end
        @(negedge clk);
        bus_a.req0_cmd = CMD_READ; bus_a.req0_addr = 9'h122;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({bus_a.busy, bus_a.bus_cmd, bus_a.grant} !== 5'b10101) begin
            miscompares++;
            $display("[TB] FAIL mid_in_wait: got busy/cmd/grant %b, expected 10101", {bus_a.busy, bus_a.bus_cmd, bus_a.grant});
        end
        reset = 1'b1;
        bus_a.req0_cmd = CMD_NONE;
        @(negedge clk);
        vectors++;
        if ({bus_a.busy, bus_a.bus_cmd, bus_a.grant, bus_a.req0_ack, bus_a.req1_ack} !== 7'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_abort: got busy/cmd/grant/acks %b, expected 0000000", {bus_a.busy, bus_a.bus_cmd, bus_a.grant, bus_a.req0_ack, bus_a.req1_ack});
        end
        vectors++;
        if (bus_a.req0_rdata !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL mid_rdata0: got %h, expected 0000", bus_a.req0_rdata);
        end
        reset = 1'b0;
        exp_rdata0 = '0;
        exp_rdata1 = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus_a.req0_ack || bus_a.req1_ack || bus_a.busy) stray++;
        end
        vectors++;
        if (stray != 0) begin
            miscompares++;
            $display("[TB] FAIL mid_no_ack: got %0d active cycles, expected 0", stray);
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_invalid_cmd();
        test_rd_lat3();
        do_reset();
        test_arbitration();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory/IO bus (RAM plus memory-mapped LED/switch decode) between two requesters: port 0 (CPU) and port 1 (secondary master, e.g. a loader/DMA).
- Each requester issues MREAD (2'b01) or MWRITE (2'b10) with a 9-bit address and 16-bit write data, then holds the request until it receives a one-cycle ack.
- The arbiter drives bus_cmd / bus_addr / bus_wdata into the existing decode logic and returns registered read data to the granted port.

Parameters:
- AW, 9, address width.
- DW, 16, data width.
- RD_LAT, 1, cycles from the end of the ACCESS cycle to valid bus_rdata; legal range 1..7.
- MAX_HOLD, 4, maximum consecutive port-0 grants while port 1 is waiting (fixed-priority mode only).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req0_cmd  in  2  port-0 command: 00 none, 01 read, 10 write, 11 treated as 00.
- req0_addr  in  AW  port-0 address.
- req0_wdata  in  DW  port-0 write data.
- req0_ack  out  1  one-cycle completion pulse.
- req0_rdata  out  DW  port-0 read data, registered.
- req1_cmd, req1_addr, req1_wdata, req1_ack, req1_rdata: same as port 0, for port 1.
- bus_cmd  out  2  command to memory/IO decode.
- bus_addr  out  AW  address to bus.
- bus_wdata  out  DW  write data to bus.
- bus_rdata  in  DW  read data from the resolved bus.
- grant  out  2  one-hot owner; 00 when IDLE.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, ACCESS, WAIT, DONE.
- Reset values (async): state IDLE, bus_cmd 00, bus_addr 0, bus_wdata 0, grant 00, busy 0, both acks 0, both rdata 0, hold counter 0, last-owner 0.
- IDLE
  - bus_cmd = 00.
  - If either port has a valid command (01/10), select an owner per the arbitration rules below.
  - Latch that port's cmd/addr/wdata into internal registers and go to ACCESS.
  - If no port has a valid command, remain in IDLE.
- ACCESS (exactly 1 cycle)
  - Drive the latched cmd/addr/wdata onto the bus.
  - grant = owner.
  - A write commits at the closing edge; next state is DONE.
  - A read goes to WAIT and loads the wait counter with RD_LAT.
- WAIT
  - bus_cmd held at the latched read command and bus_addr held, so the switch/RAM tristates stay enabled.
  - The counter decrements each cycle.
  - On the cycle the counter equals 1, capture bus_rdata into the owner's rdata register at the closing edge, then go to DONE.
- DONE (1 cycle)
  - bus_cmd = 00.
  - Owner's ack = 1.
  - Go to IDLE.
- rdata
  - Updated only on a read by that port.
  - Holds its value across writes and across the other port's transactions.
- Latency from request visible in IDLE to ack:
  - Write: ack 2 cycles later.
  - Read: ack 2+RD_LAT cycles later.
- Handshake
  - Requester keeps cmd/addr/wdata stable until it sees ack.
  - Requester may change or present a new command in the cycle after ack.
  - The arbiter ignores requester inputs outside IDLE, because they are latched.
- Arbitration, fixed-priority mode
  - Port 0 wins ties.
  - The hold counter increments on each port-0 grant taken while req1 is valid; it saturates at MAX_HOLD.
  - When the counter equals MAX_HOLD and port 1 is valid, port 1 wins and the counter clears.
  - Any port-1 grant, or any grant with req1 idle, clears the counter.
- Reset mid-transaction: abort immediately to IDLE; no ack is issued; a write in ACCESS may or may not have committed.
- Only one transaction is outstanding at a time. Back-to-back transactions have a minimum 1-cycle IDLE gap.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - Round-robin arbitration; on simultaneous requests the port not granted last wins.
  - last-owner resets to 0, so port 1 wins the first tie after reset.
  - Hold counter and MAX_HOLD are unused.
- Undefined: fixed priority with MAX_HOLD starvation guard, as in Behaviour.

Test Plan:
- Port-0 write addr 0x005, data 0xBEEF, port 1 idle -> bus_cmd=10 with addr 0x005 / data 0xBEEF for exactly 1 cycle; grant=01; req0_ack pulses 2 cycles after request; req1_ack stays 0.
- Port-1 read addr 0x140, bus_rdata=0x00A5, RD_LAT=1 -> bus_cmd=01 for 2 cycles; req1_rdata=0x00A5 when req1_ack pulses (3 cycles after request); req0_rdata unchanged.
- Both ports continuously request reads, fixed priority, MAX_HOLD=4 -> grant order 0,0,0,0,1,0,0,0,0,1.
- Same stimulus with ARB_ROUND_ROBIN_EN -> grant order 1,0,1,0,...
- Assert reset during WAIT of a port-0 read -> next cycle: IDLE, bus_cmd=00, grant=00, no ack, req0_rdata=0.
- req0_cmd=11 with port 1 idle -> arbiter stays IDLE, busy=0, no ack; RD_LAT=3 read -> ack 5 cycles after request.
